// File: rtl/led_panel_pkg.sv
// Shared definitions for the LED-panel scan path: sequencer states, RGB word
// width and the frame-buffer {row,col} address packing helper.
package led_panel_pkg;

  localparam int RGB_W = 6;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_SHIFT_LO = 4'd2,
    S_SHIFT_HI = 4'd3,
    S_BLANK    = 4'd4,
    S_LATCH    = 4'd5,
    S_UNLATCH  = 4'd6,
    S_SHOW     = 4'd7,
    S_WAIT     = 4'd8
  } scan_state_e;

  // Callers truncate the result to ROW_W+COL_W bits.
  function automatic logic [31:0] pack_addr(input logic [31:0] row,
                                            input logic [31:0] col,
                                            input int          col_w);
    return (row << col_w) | col;
  endfunction

endpackage

// File: rtl/hub75_scan_sequencer_if.sv
// Signal bundle between the scan sequencer (master) and its environment:
// frame-buffer read port, HUB75 panel lines and timing-controller commands.
interface hub75_scan_sequencer_if #(
  parameter int COLS = 64,
  parameter int ROWS = 16
);
  import led_panel_pkg::*;

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  logic                   enable;
  logic [ROW_W+COL_W-1:0] rd_addr;
  logic [RGB_W-1:0]       rd_data;
  logic [RGB_W-1:0]       rgb;
  logic                   sclk;
  logic [ROW_W-1:0]       row_addr;
  logic                   delay_start;
  logic                   delay_done;
  logic                   latch_set;
  logic                   latch_clr;
  logic                   oe_enable;
  logic                   oe_disable;
  logic                   frame_done;
  logic                   busy;

  modport master (
    input  enable, rd_data, delay_done,
    output rd_addr, rgb, sclk, row_addr, delay_start, latch_set, latch_clr,
           oe_enable, oe_disable, frame_done, busy
  );

  modport slave (
    output enable, rd_data, delay_done,
    input  rd_addr, rgb, sclk, row_addr, delay_start, latch_set, latch_clr,
           oe_enable, oe_disable, frame_done, busy
  );

endinterface

// File: rtl/hub75_scan_sequencer.sv
// HUB75 row scanner: fetches pixel words, shifts them out on rgb/sclk and issues
// the blank/latch/unlatch/show command pulses at the end of every row.
module hub75_scan_sequencer
  import led_panel_pkg::*;
#(
  parameter int COLS = 64,
  parameter int ROWS = 16
) (
  input logic                    clk,
  input logic                    rst,
  hub75_scan_sequencer_if.master bus
);

  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int ADDR_W = ROW_W + COL_W;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  scan_state_e       state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [RGB_W-1:0]  rgb_q, rgb_d;
  logic              sclk_q, sclk_d;
  logic [ROW_W-1:0]  row_addr_q, row_addr_d;
  logic              delay_start_q, delay_start_d;
  logic              latch_set_q, latch_set_d;
  logic              latch_clr_q, latch_clr_d;
  logic              oe_enable_q, oe_enable_d;
  logic              oe_disable_q, oe_disable_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;
  logic [ROW_W-1:0]  row_next_s;

  assign row_next_s = (row_q == LAST_ROW) ? {ROW_W{1'b0}} : row_q + ROW_W'(1);

  // Next-state and registered-output decode. rd_addr runs one cycle ahead of
  // the state that consumes rd_data, so the word is ready in SHIFT_LO.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    rd_addr_d     = rd_addr_q;
    rgb_d         = rgb_q;
    sclk_d        = sclk_q;
    row_addr_d    = row_addr_q;
    delay_start_d = 1'b0;
    latch_set_d   = 1'b0;
    latch_clr_d   = 1'b0;
    oe_enable_d   = 1'b0;
    oe_disable_d  = 1'b0;
    frame_done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.enable) begin
          state_d   = S_FETCH;
          rd_addr_d = ADDR_W'(pack_addr(32'(row_q), 32'd0, COL_W));
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: state_d = S_SHIFT_LO;
      S_SHIFT_LO: begin
        rgb_d   = bus.rd_data;
        sclk_d  = 1'b0;
        state_d = S_SHIFT_HI;
        if (col_q != LAST_COL) begin
          rd_addr_d = ADDR_W'(pack_addr(32'(row_q), 32'(col_q + COL_W'(1)), COL_W));
        end else begin
          rd_addr_d = rd_addr_q;
        end
      end
      S_SHIFT_HI: begin
        sclk_d = 1'b1;
        if (col_q != LAST_COL) begin
          col_d   = col_q + COL_W'(1);
          state_d = S_SHIFT_LO;
        end else begin
          col_d   = {COL_W{1'b0}};
          state_d = S_BLANK;
        end
      end
      S_BLANK: begin
        oe_disable_d = 1'b1;
        sclk_d       = 1'b0;
        state_d      = S_LATCH;
      end
      S_LATCH: begin
        latch_set_d = 1'b1;
        row_addr_d  = row_q;
        state_d     = S_UNLATCH;
      end
      S_UNLATCH: begin
        latch_clr_d = 1'b1;
        state_d     = S_SHOW;
      end
      S_SHOW: begin
        oe_enable_d   = 1'b1;
        delay_start_d = 1'b1;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        if (bus.delay_done) begin
          row_d        = row_next_s;
          frame_done_d = (row_q == LAST_ROW);
          if (bus.enable) begin
            state_d   = S_FETCH;
            rd_addr_d = ADDR_W'(pack_addr(32'(row_next_s), 32'd0, COL_W));
          end else begin
            oe_disable_d = 1'b1;
            state_d      = S_IDLE;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, counters and output registers; rst clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      row_q         <= {ROW_W{1'b0}};
      col_q         <= {COL_W{1'b0}};
      rd_addr_q     <= {ADDR_W{1'b0}};
      rgb_q         <= {RGB_W{1'b0}};
      sclk_q        <= 1'b0;
      row_addr_q    <= {ROW_W{1'b0}};
      delay_start_q <= 1'b0;
      latch_set_q   <= 1'b0;
      latch_clr_q   <= 1'b0;
      oe_enable_q   <= 1'b0;
      oe_disable_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      rd_addr_q     <= rd_addr_d;
      rgb_q         <= rgb_d;
      sclk_q        <= sclk_d;
      row_addr_q    <= row_addr_d;
      delay_start_q <= delay_start_d;
      latch_set_q   <= latch_set_d;
      latch_clr_q   <= latch_clr_d;
      oe_enable_q   <= oe_enable_d;
      oe_disable_q  <= oe_disable_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.rd_addr     = rd_addr_q;
  assign bus.rgb         = rgb_q;
  assign bus.sclk        = sclk_q;
  assign bus.row_addr    = row_addr_q;
  assign bus.delay_start = delay_start_q;
  assign bus.latch_set   = latch_set_q;
  assign bus.latch_clr   = latch_clr_q;
  assign bus.oe_enable   = oe_enable_q;
  assign bus.oe_disable  = oe_disable_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_hub75_scan_sequencer.sv
// Directed bench for hub75_scan_sequencer with COLS=4, ROWS=2; expected cycle
// tables are written out by hand relative to the first FETCH cycle of each row.
module tb_hub75_scan_sequencer;
  import led_panel_pkg::*;

  localparam int COLS = 4;
  localparam int ROWS = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  hub75_scan_sequencer_if #(.COLS(COLS), .ROWS(ROWS)) bus_if ();

  hub75_scan_sequencer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] pat(input int addr);
    logic [2:0] a;
    a = 3'(addr);
    return {a, a ^ 3'b101};
  endfunction

  // Frame-buffer model: data follows the address by exactly one cycle.
  always @(posedge clk) bus_if.rd_data <= pat(int'(bus_if.rd_addr));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] obs_vec();
    return {bus_if.sclk, bus_if.oe_disable, bus_if.latch_set, bus_if.latch_clr,
            bus_if.oe_enable, bus_if.delay_start, bus_if.frame_done, bus_if.busy};
  endfunction

  // Runs one row from its FETCH cycle (c0) through the first WAIT cycle (c13).
  task automatic do_row(input int r, input bit noisy, input bit fd_first, input bit drop_en);
    logic [7:0] exp_v;
    bit sclk_e;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      sclk_e = (c == 3) || (c == 5) || (c == 7) || (c == 9);
      exp_v  = {sclk_e, c == 10, c == 11, c == 12, c == 13, c == 13,
                (c == 0) && fd_first, 1'b1};
      check_eq($sformatf("row%0d_c%0d_ctrl", r, c), 32'(obs_vec()), 32'(exp_v));
      if (sclk_e) check_eq($sformatf("row%0d_rgb_edge%0d", r, (c - 3) / 2),
                           32'(bus_if.rgb), 32'(pat(r * COLS + (c - 3) / 2)));
      if (c == 0) check_eq($sformatf("row%0d_fetch_addr", r), 32'(bus_if.rd_addr), 32'(r * COLS));
      if (c == 12) check_eq($sformatf("row%0d_row_addr", r), 32'(bus_if.row_addr), 32'(r));
      bus_if.delay_done = noisy && (c <= 9);
      if (drop_en && (c == 4)) bus_if.enable = 1'b0;
    end
  endtask

  // Holds WAIT for 'hold' cycles, then completes the delay with enable=en_next.
  task automatic finish_row(input int hold, input bit en_next, input bit fd_exp);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      acc |= obs_vec();
    end
    if (hold > 0) check_eq("wait_quiet", 32'(acc), 32'h1);
    bus_if.delay_done = 1'b1;
    bus_if.enable     = en_next;
    if (!en_next) begin
      @(negedge clk);
      bus_if.delay_done = 1'b0;
      check_eq("stop_pulse", 32'(obs_vec()), 32'({1'b0, 1'b1, 4'b0000, fd_exp, 1'b0}));
      acc = 8'h00;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        acc |= obs_vec();
      end
      check_eq("stays_idle", 32'(acc), 32'h0);
    end
  endtask

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    rst               = 1'b1;
    bus_if.enable     = 1'b0;
    bus_if.delay_done = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_ctrl", 32'(obs_vec()), 32'h0);
    check_eq("reset_rgb", 32'(bus_if.rgb), 32'h0);
    check_eq("reset_row_addr", 32'(bus_if.row_addr), 32'h0);
    check_eq("reset_rd_addr", 32'(bus_if.rd_addr), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_no_enable", 32'(obs_vec()), 32'h0);

    bus_if.enable = 1'b1;
    do_row(0, 1'b0, 1'b0, 1'b0);
    finish_row(50, 1'b1, 1'b0);
    do_row(1, 1'b0, 1'b0, 1'b0);
    finish_row(0, 1'b1, 1'b0);
    do_row(0, 1'b1, 1'b1, 1'b0);
    finish_row(2, 1'b1, 1'b0);
    do_row(1, 1'b0, 1'b0, 1'b1);
    finish_row(3, 1'b0, 1'b1);

    // Restart, then hit rst asynchronously in the middle of a SHIFT_HI cycle.
    bus_if.enable = 1'b1;
    repeat (7) @(negedge clk);
    check_eq("pre_rst_busy", 32'(bus_if.busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_ctrl", 32'(obs_vec()), 32'h0);
    check_eq("async_rst_rgb", 32'(bus_if.rgb), 32'h0);
    check_eq("async_rst_row_addr", 32'(bus_if.row_addr), 32'h0);
    check_eq("async_rst_rd_addr", 32'(bus_if.rd_addr), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_row(0, 1'b0, 1'b0, 1'b0);
    finish_row(0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
